// File: rtl/demux1to4_buffered_if.sv
// Handshake bundle for the 1-to-4 buffered demultiplexer: one input stream, four output channels
// and their delivered-word counters.
interface demux1to4_buffered_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNTW  = 8
);
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic [1:0]       sel;
   logic             in_ready;
   logic [3:0]       out_valid;
   logic [WIDTH-1:0] out_data0;
   logic [WIDTH-1:0] out_data1;
   logic [WIDTH-1:0] out_data2;
   logic [WIDTH-1:0] out_data3;
   logic [3:0]       out_ready;
   logic [CNTW-1:0]  cnt0;
   logic [CNTW-1:0]  cnt1;
   logic [CNTW-1:0]  cnt2;
   logic [CNTW-1:0]  cnt3;

   // Producer/consumer side.
   modport master (
      output in_valid, in_data, sel, out_ready,
      input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3,
      input  cnt0, cnt1, cnt2, cnt3
   );

   // Demultiplexer side.
   modport slave (
      input  in_valid, in_data, sel, out_ready,
      output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3,
      output cnt0, cnt1, cnt2, cnt3
   );
endinterface

// File: rtl/demux1to4_buffered.sv
// 1-to-4 demultiplexer with a one-entry register per output channel, so a stalled consumer only
// blocks words aimed at its own channel. Each channel counts the words it delivers.
module demux1to4_buffered #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNTW  = 8
) (
   input logic                 clk,
   input logic                 rst,
   demux1to4_buffered_if.slave bus_io
);
   typedef enum logic {StEmpty, StFull} ch_state_e;

   ch_state_e        state_q [4];
   ch_state_e        state_d [4];
   logic [WIDTH-1:0] data_q  [4];
   logic [CNTW-1:0]  cnt_q   [4];
   logic [3:0]       valid;
   logic [3:0]       load;
   logic [3:0]       drain;
   logic             in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) state_q[i] <= StEmpty;
      end else begin
         for (int i = 0; i < 4; i++) state_q[i] <= state_d[i];
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         state_d[i] = state_q[i];
         unique case (state_q[i])
            StEmpty: if (load[i]) state_d[i] = StFull;
            // A load in the same cycle as a drain keeps the channel full with the new word.
            StFull:  if (drain[i] && !load[i]) state_d[i] = StEmpty;
            default: state_d[i] = StEmpty;
         endcase
      end
   end

   always_comb begin
      valid = '0;
      for (int i = 0; i < 4; i++) valid[i] = (state_q[i] == StFull);
      // Only the selected channel can hold off the input.
      in_ready = ~valid[bus_io.sel] | bus_io.out_ready[bus_io.sel];
      load  = '0;
      drain = '0;
      for (int i = 0; i < 4; i++) begin
         load[i]  = bus_io.in_valid & in_ready & (bus_io.sel == 2'(i));
         drain[i] = valid[i] & bus_io.out_ready[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            data_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (load[i])  data_q[i] <= bus_io.in_data;
            if (drain[i]) cnt_q[i]  <= cnt_q[i] + CNTW'(1);
         end
      end
   end

   assign bus_io.in_ready  = in_ready;
   assign bus_io.out_valid = valid;
   assign bus_io.out_data0 = data_q[0];
   assign bus_io.out_data1 = data_q[1];
   assign bus_io.out_data2 = data_q[2];
   assign bus_io.out_data3 = data_q[3];
   assign bus_io.cnt0      = cnt_q[0];
   assign bus_io.cnt1      = cnt_q[1];
   assign bus_io.cnt2      = cnt_q[2];
   assign bus_io.cnt3      = cnt_q[3];
endmodule

// File: tb/tb_demux1to4_buffered.sv
// Directed bench for demux1to4_buffered: reset, routing, channel isolation, pass-through,
// back-to-back sweep and counter wrap, each with hand-computed expectations.
module tb_demux1to4_buffered;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   demux1to4_buffered_if #(.WIDTH(8), .CNTW(8)) bus ();

   demux1to4_buffered #(.WIDTH(8), .CNTW(8)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus.slave)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] data_of(input int ch);
      case (ch)
         0:       return bus.out_data0;
         1:       return bus.out_data1;
         2:       return bus.out_data2;
         default: return bus.out_data3;
      endcase
   endfunction

   task automatic test_reset();
      bus.out_ready = 4'b1011;
      step();
      bus.in_valid = 1'b1; bus.sel = 2'd0; bus.in_data = 8'h77;
      step();
      bus.sel = 2'd2; bus.in_data = 8'h99;
      step();
      bus.in_valid = 1'b0;
      n_checks++;
      if (bus.out_valid !== 4'b0100 || bus.cnt0 !== 8'd1) begin
         n_fail++;
         $display("FAIL reset_pre: out_valid=%b cnt0=%0d, required 0100 and 1", bus.out_valid, bus.cnt0);
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (bus.out_valid !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_valid: out_valid=%b, required 0000", bus.out_valid);
      end
      n_checks++;
      if ({bus.cnt0, bus.cnt1, bus.cnt2, bus.cnt3} !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_cnt: cnt0..3=%h %h %h %h, required 0", bus.cnt0, bus.cnt1, bus.cnt2,
                  bus.cnt3);
      end
      n_checks++;
      if (bus.out_data0 !== 8'h00 || bus.out_data2 !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_data: data0=%h data2=%h, required 00", bus.out_data0, bus.out_data2);
      end
      step();
      rst = 1'b0;
   endtask

   task automatic test_route();
      bus.out_ready = 4'b1111;
      step();
      bus.in_valid = 1'b1; bus.sel = 2'd1; bus.in_data = 8'hA5;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL route_ready: in_ready=%b, required 1", bus.in_ready);
      end
      step();
      bus.in_valid = 1'b0;
      n_checks++;
      if (bus.out_valid !== 4'b0010 || bus.out_data1 !== 8'hA5) begin
         n_fail++;
         $display("FAIL route_load: out_valid=%b data1=%h, required 0010 A5", bus.out_valid,
                  bus.out_data1);
      end
      step();
      n_checks++;
      if (bus.out_valid !== 4'b0000 || bus.cnt1 !== 8'd1 || bus.out_data1 !== 8'hA5) begin
         n_fail++;
         $display("FAIL route_drain: out_valid=%b cnt1=%0d data1=%h, required 0000 1 A5",
                  bus.out_valid, bus.cnt1, bus.out_data1);
      end
   endtask

   task automatic test_isolation();
      bus.out_ready = 4'b1110;
      bus.in_valid = 1'b1; bus.sel = 2'd0; bus.in_data = 8'h11;
      step();
      bus.in_data = 8'h22;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 4'b0001 || bus.out_data0 !== 8'h11) begin
         n_fail++;
         $display("FAIL iso_stall: in_ready=%b out_valid=%b data0=%h, required 0 0001 11",
                  bus.in_ready, bus.out_valid, bus.out_data0);
      end
      step();
      n_checks++;
      if (bus.out_valid !== 4'b0001 || bus.out_data0 !== 8'h11) begin
         n_fail++;
         $display("FAIL iso_hold: out_valid=%b data0=%h, required 0001 11", bus.out_valid,
                  bus.out_data0);
      end
      bus.sel = 2'd3; bus.in_data = 8'h33;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL iso_switch: in_ready=%b, required 1", bus.in_ready);
      end
      step();
      bus.in_valid = 1'b0;
      n_checks++;
      if (bus.out_valid !== 4'b1001 || bus.out_data3 !== 8'h33) begin
         n_fail++;
         $display("FAIL iso_ch3: out_valid=%b data3=%h, required 1001 33", bus.out_valid,
                  bus.out_data3);
      end
      step();
      n_checks++;
      if (bus.out_valid !== 4'b0001 || bus.cnt3 !== 8'd1 || bus.cnt0 !== 8'd0) begin
         n_fail++;
         $display("FAIL iso_cnt: out_valid=%b cnt3=%0d cnt0=%0d, required 0001 1 0",
                  bus.out_valid, bus.cnt3, bus.cnt0);
      end
      bus.out_ready = 4'b1111;
      step();
      n_checks++;
      if (bus.out_valid !== 4'b0000 || bus.cnt0 !== 8'd1 || bus.out_data0 !== 8'h11) begin
         n_fail++;
         $display("FAIL iso_release: out_valid=%b cnt0=%0d data0=%h, required 0000 1 11",
                  bus.out_valid, bus.cnt0, bus.out_data0);
      end
   endtask

   task automatic test_pass_through();
      bus.out_ready = 4'b1011;
      bus.in_valid = 1'b1; bus.sel = 2'd2; bus.in_data = 8'h44;
      step();
      bus.out_ready = 4'b1111; bus.in_data = 8'h55;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1 || bus.out_data2 !== 8'h44) begin
         n_fail++;
         $display("FAIL pass_ready: in_ready=%b data2=%h, required 1 44", bus.in_ready,
                  bus.out_data2);
      end
      step();
      bus.in_valid = 1'b0;
      n_checks++;
      if (bus.out_valid !== 4'b0100 || bus.out_data2 !== 8'h55 || bus.cnt2 !== 8'd1) begin
         n_fail++;
         $display("FAIL pass_swap: out_valid=%b data2=%h cnt2=%0d, required 0100 55 1",
                  bus.out_valid, bus.out_data2, bus.cnt2);
      end
      step();
      n_checks++;
      if (bus.out_valid !== 4'b0000 || bus.cnt2 !== 8'd2) begin
         n_fail++;
         $display("FAIL pass_drain: out_valid=%b cnt2=%0d, required 0000 2", bus.out_valid,
                  bus.cnt2);
      end
   endtask

   task automatic test_back_to_back();
      bus.out_ready = 4'b1111;
      for (int s = 0; s < 4; s++) begin
         if (s > 0) begin
            n_checks++;
            if (bus.out_valid !== (4'b0001 << (s - 1)) || data_of(s - 1) !== 8'(8'h10 + s - 1)) begin
               n_fail++;
               $display("FAIL sweep_ch%0d: out_valid=%b data=%h, required %b %h", s - 1,
                        bus.out_valid, data_of(s - 1), 4'b0001 << (s - 1), 8'(8'h10 + s - 1));
            end
         end
         bus.in_valid = 1'b1; bus.sel = 2'(s); bus.in_data = 8'(8'h10 + s);
         #1;
         n_checks++;
         if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL sweep_ready%0d: in_ready=%b, required 1", s, bus.in_ready);
         end
         step();
      end
      bus.in_valid = 1'b0;
      n_checks++;
      if (bus.out_valid !== 4'b1000 || bus.out_data3 !== 8'h13) begin
         n_fail++;
         $display("FAIL sweep_ch3: out_valid=%b data3=%h, required 1000 13", bus.out_valid,
                  bus.out_data3);
      end
      step();
      n_checks++;
      if ({bus.cnt0, bus.cnt1, bus.cnt2, bus.cnt3} !== {8'd2, 8'd2, 8'd3, 8'd2}) begin
         n_fail++;
         $display("FAIL sweep_cnt: cnt0..3=%0d %0d %0d %0d, required 2 2 3 2", bus.cnt0,
                  bus.cnt1, bus.cnt2, bus.cnt3);
      end
   endtask

   task automatic test_counter_wrap();
      bus.out_ready = 4'b1111;
      bus.in_valid = 1'b1; bus.sel = 2'd3;
      // After edge i, i-1 words have drained from ch3 (2 drains already counted).
      for (int i = 1; i <= 256; i++) begin
         bus.in_data = 8'(i);
         step();
         if (i == 255) begin
            n_checks++;
            if (bus.cnt3 !== 8'd0) begin
               n_fail++;
               $display("FAIL wrap_zero: cnt3=%0d, required 0", bus.cnt3);
            end
         end
      end
      bus.in_valid = 1'b0;
      step();
      n_checks++;
      if (bus.cnt3 !== 8'd2 || bus.out_valid !== 4'b0000) begin
         n_fail++;
         $display("FAIL wrap_end: cnt3=%0d out_valid=%b, required 2 0000", bus.cnt3,
                  bus.out_valid);
      end
      n_checks++;
      if ({bus.cnt0, bus.cnt1, bus.cnt2} !== {8'd2, 8'd2, 8'd3}) begin
         n_fail++;
         $display("FAIL wrap_others: cnt0..2=%0d %0d %0d, required 2 2 3", bus.cnt0, bus.cnt1,
                  bus.cnt2);
      end
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = 8'h00;
      bus.sel       = 2'd0;
      bus.out_ready = 4'b0000;
      step();
      step();
      rst = 1'b0;
      test_reset();
      test_route();
      test_isolation();
      test_pass_through();
      test_back_to_back();
      test_counter_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
